// File: rtl/display_scan_if.sv
// Signal bundle between the microwave controller and the 4-digit LED scan driver.
// The controller is the master; the scan driver is the slave and owns the display pins.
interface display_scan_if;
  logic       mag_on;
  logic [6:0] sec_ones_segs;
  logic [6:0] sec_tens_segs;
  logic [6:0] min_ones_segs;
  logic [6:0] min_tens_segs;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       colon_n;

  modport master (
    output mag_on, sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs,
    input  seg_n, an_n, colon_n
  );

  modport slave (
    input  mag_on, sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs,
    output seg_n, an_n, colon_n
  );
endinterface

// File: rtl/display_scan_driver.sv
// Time-multiplexed common-anode 4-digit display driver with guard gaps between digits,
// leading-zero blanking on the minutes digits and a colon that blinks while cooking.
module display_scan_driver #(
  parameter int unsigned REFRESH_DIV = 250,
  parameter int unsigned GUARD       = 2,
  parameter int unsigned BLINK_DIV   = 50
) (
  input  logic           clk,
  input  logic           rst,
  display_scan_if.slave  bus
);

  localparam int unsigned MaxSlot = (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
  localparam int unsigned SlotW   = (MaxSlot > 1) ? $clog2(MaxSlot) : 1;
  localparam int unsigned BlinkW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SlotW-1:0]  ActiveLast = SlotW'(REFRESH_DIV - 1);
  localparam logic [SlotW-1:0]  GuardLast  = SlotW'(GUARD - 1);
  localparam logic [BlinkW-1:0] BlinkLast  = BlinkW'(BLINK_DIV - 1);

  typedef enum logic [0:0] {StActive, StGuard} state_e;

  state_e           state_q;
  logic [1:0]       idx_q;
  logic [SlotW-1:0] slot_cnt_q;
  logic [6:0]       seg_n_q;
  logic [3:0]       an_n_q;

  logic              mag_prev_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              colon_n_q;

  logic [1:0] idx_next;
  logic       min_tens_blank;
  logic       min_ones_blank;
  logic [6:0] cap_segs;

  assign idx_next = idx_q + 2'd1;

  // Pattern for the digit about to be shown, with leading zeros of the minutes blanked.
  always_comb begin
    min_tens_blank = (bus.min_tens_segs == 7'h3F);
    min_ones_blank = min_tens_blank && (bus.min_ones_segs == 7'h3F);
    cap_segs       = 7'h00;
    unique case (idx_next)
      2'd0: cap_segs = bus.sec_ones_segs;
      2'd1: cap_segs = bus.sec_tens_segs;
      2'd2: cap_segs = min_ones_blank ? 7'h00 : bus.min_ones_segs;
      2'd3: cap_segs = min_tens_blank ? 7'h00 : bus.min_tens_segs;
      default: cap_segs = 7'h00;
    endcase
  end

  // Scan FSM; reset parks in a terminal GUARD at digit 3 so release starts digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StGuard;
      idx_q      <= 2'd3;
      slot_cnt_q <= '0;
      seg_n_q    <= 7'h7F;
      an_n_q     <= 4'hF;
    end else begin
      unique case (state_q)
        StActive: begin
          if (slot_cnt_q == '0) begin
            state_q    <= StGuard;
            slot_cnt_q <= GuardLast;
            seg_n_q    <= 7'h7F;
            an_n_q     <= 4'hF;
          end else begin
            slot_cnt_q <= slot_cnt_q - 1'b1;
          end
        end
        StGuard: begin
          if (slot_cnt_q == '0) begin
            state_q    <= StActive;
            slot_cnt_q <= ActiveLast;
            idx_q      <= idx_next;
            seg_n_q    <= ~cap_segs;
            an_n_q     <= ~(4'b0001 << idx_next);
          end else begin
            slot_cnt_q <= slot_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q    <= StGuard;
          slot_cnt_q <= '0;
        end
      endcase
    end
  end

  // Colon: steady on when idle; blinks while cooking, restarting on each mag_on rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_prev_q  <= 1'b0;
      blink_cnt_q <= '0;
      colon_n_q   <= 1'b1;
    end else begin
      mag_prev_q <= bus.mag_on;
      if (!bus.mag_on || !mag_prev_q) begin
        colon_n_q   <= 1'b0;
        blink_cnt_q <= '0;
      end else if (blink_cnt_q == BlinkLast) begin
        colon_n_q   <= ~colon_n_q;
        blink_cnt_q <= '0;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign bus.seg_n   = seg_n_q;
  assign bus.an_n    = an_n_q;
  assign bus.colon_n = colon_n_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver: stimulus pushes the expected per-cycle display
// state computed from slot arithmetic; a monitor pops and compares after every clock edge.
module tb_display_scan_driver;

  localparam int R    = 4;
  localparam int G    = 1;
  localparam int B    = 10;
  localparam int SLOT = R + G;
  localparam int PER  = 4 * SLOT;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       colon;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  display_scan_if bus ();

  display_scan_driver #(
    .REFRESH_DIV(R),
    .GUARD      (G),
    .BLINK_DIV  (B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: cycles since reset release, latched slot pattern, blink timer.
  int         t        = -1;
  logic [6:0] cur_seg  = 7'h7F;
  logic       prev_mag = 1'b0;
  int         bt       = 0;

  function automatic logic [6:0] digit_pat(int d);
    logic mt_blank;
    mt_blank = (bus.min_tens_segs == 7'h3F);
    case (d)
      0:       return bus.sec_ones_segs;
      1:       return bus.sec_tens_segs;
      2:       return (mt_blank && bus.min_ones_segs == 7'h3F) ? 7'h00 : bus.min_ones_segs;
      default: return mt_blank ? 7'h00 : bus.min_tens_segs;
    endcase
  endfunction

  // Predict the outputs after the coming edge from the inputs now driven, then advance.
  task automatic step();
    exp_t       e;
    int         pos;
    int         d;
    int         k;
    logic [3:0] onehot;
    if (rst) begin
      t        = -1;
      prev_mag = 1'b0;
      bt       = 0;
      e.an     = 4'hF;
      e.seg    = 7'h7F;
      e.colon  = 1'b1;
    end else begin
      t++;
      pos = t % PER;
      d   = pos / SLOT;
      k   = pos % SLOT;
      if (k == 0) cur_seg = ~digit_pat(d);
      if (k < R) begin
        onehot = 4'b0001 << d;
        e.an   = ~onehot;
        e.seg  = cur_seg;
      end else begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
      end
      if (bus.mag_on) begin
        bt      = prev_mag ? bt + 1 : 0;
        e.colon = ((bt / B) % 2) == 1;
      end else begin
        e.colon = 1'b0;
      end
      prev_mag = bus.mag_on;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check(string name, logic [6:0] act, logic [6:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every edge produces a new display state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("an_n", {3'b0, bus.an_n}, {3'b0, e.an});
        check("seg_n", bus.seg_n, e.seg);
        check("colon_n", {6'b0, bus.colon_n}, {6'b0, e.colon});
        check("an_overlap", {6'b0, ($countones(~bus.an_n) <= 1)}, 7'd1);
      end
    end
  end

  task automatic set_time(logic [6:0] mt, logic [6:0] mo, logic [6:0] st, logic [6:0] so);
    bus.min_tens_segs = mt;
    bus.min_ones_segs = mo;
    bus.sec_tens_segs = st;
    bus.sec_ones_segs = so;
  endtask

  initial begin
    rst        = 1'b1;
    bus.mag_on = 1'b0;
    set_time(7'h06, 7'h5B, 7'h4F, 7'h66);
    repeat (3) step();
    rst = 1'b0;

    // 12:34 scan order.
    repeat (2 * PER + 5) step();

    // Leading-zero blanking: 00:05 then 00:00.
    set_time(7'h3F, 7'h3F, 7'h3F, 7'h6D);
    repeat (PER + 2) step();
    set_time(7'h3F, 7'h3F, 7'h3F, 7'h3F);
    repeat (PER + 2) step();

    // Mid-slot change on slot 0.
    set_time(7'h06, 7'h5B, 7'h4F, 7'h06);
    while (t % PER != PER - 1) step();
    while (t % PER != 1) step();
    bus.sec_ones_segs = 7'h5B;
    repeat (PER + 5) step();

    // Colon blink, then drop/re-raise during the off phase.
    repeat (5) step();
    bus.mag_on = 1'b1;
    repeat (35) step();
    bus.mag_on = 1'b0;
    step();
    bus.mag_on = 1'b1;
    repeat (30) step();
    bus.mag_on = 1'b0;
    repeat (5) step();

    // One-cycle reset during slot 2.
    while (t % PER != 2 * SLOT + 1) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (30) step();

    // Randomized inputs, mag_on toggles and occasional reset pulses.
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [6:0] v;
        v = ($urandom_range(0, 2) == 0) ? 7'h3F : 7'($urandom_range(0, 127));
        case ($urandom_range(0, 3))
          0:       bus.sec_ones_segs = v;
          1:       bus.sec_tens_segs = v;
          2:       bus.min_ones_segs = v;
          default: bus.min_tens_segs = v;
        endcase
      end
      if ($urandom_range(0, 24) == 0) bus.mag_on = ~bus.mag_on;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    step();

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
